// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM encoding, funct3 codes and
// the access-legality check.
package lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_MERGE = 3'd3,
    ST_DONE  = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Misaligned halfword/word, or a funct3 that has no meaning for the direction.
  function automatic logic is_bad_access(input logic store, input logic [2:0] f3,
                                         input logic [1:0] lane);
    logic bad;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lane[0];
      F3_W:    bad = (lane != 2'b00);
      F3_BU:   bad = store;
      F3_HU:   bad = store | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and datam-side bus of the load/store unit.
interface lsu_if;
  import lsu_pkg::*;

  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
    output stall, done, rdata, err, mem_a, mem_wd, mem_we
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
    input  stall, done, rdata, err, mem_a, mem_wd, mem_we
  );
endinterface

// File: rtl/lsu_align.sv
// Lane steering: load byte/half extraction with extension, and the
// read-modify-write merge for sub-word stores.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte/half and build the load and merge words.
  always_comb begin
    load_data_o  = rd_word_i;
    merge_data_o = rd_word_i;
    half_s       = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
    case (lane_i)
      2'd0:    byte_s = rd_word_i[7:0];
      2'd1:    byte_s = rd_word_i[15:8];
      2'd2:    byte_s = rd_word_i[23:16];
      2'd3:    byte_s = rd_word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    case (funct3_i)
      F3_B: begin
        load_data_o = {{24{byte_s[7]}}, byte_s};
        case (lane_i)
          2'd0:    merge_data_o[7:0]   = wdata_i[7:0];
          2'd1:    merge_data_o[15:8]  = wdata_i[7:0];
          2'd2:    merge_data_o[23:16] = wdata_i[7:0];
          2'd3:    merge_data_o[31:24] = wdata_i[7:0];
          default: merge_data_o        = rd_word_i;
        endcase
      end
      F3_H: begin
        load_data_o = {{16{half_s[15]}}, half_s};
        if (lane_i[1]) begin
          merge_data_o[31:16] = wdata_i[15:0];
        end else begin
          merge_data_o[15:0] = wdata_i[15:0];
        end
      end
      F3_W: begin
        load_data_o  = rd_word_i;
        merge_data_o = wdata_i;
      end
      F3_BU:   load_data_o = {24'h000000, byte_s};
      F3_HU:   load_data_o = {16'h0000, half_s};
      default: load_data_o = rd_word_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer for a word-wide, single-write-enable, synchronous-read
// data memory: stalls the core, does RMW for SB/SH and formats loads.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic  clk,
  input  logic  reset,
  lsu_if.slave  bus
);

  localparam logic [1:0] LAT_C = 2'(MEM_RD_LAT);

  lsu_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_wd_q, mem_wd_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] load_data_s;
  logic [31:0] merge_data_s;

  lsu_align u_align (
    .funct3_i     (funct3_q),
    .lane_i       (lane_q),
    .rd_word_i    (bus.mem_rd),
    .wdata_i      (wdata_q),
    .load_data_o  (load_data_s),
    .merge_data_o (merge_data_s)
  );

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      lane_q   <= 2'd0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      mem_a_q  <= 32'h0;
      mem_wd_q <= 32'h0;
      mem_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      lane_q   <= lane_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      mem_a_q  <= mem_a_d;
      mem_wd_q <= mem_wd_d;
      mem_we_q <= mem_we_d;
    end
  end

  // Next-state logic; mem_we is only ever raised on entry to WR or MERGE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    lane_d   = lane_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    mem_a_d  = mem_a_q;
    mem_wd_d = mem_wd_q;
    mem_we_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          store_d  = bus.req_store;
          funct3_d = bus.req_funct3;
          lane_d   = bus.req_addr[1:0];
          wdata_d  = bus.req_wdata;
          mem_a_d  = {bus.req_addr[31:2], 2'b00};
          cnt_d    = 2'd0;
          err_d    = is_bad_access(bus.req_store, bus.req_funct3, bus.req_addr[1:0]);
          if (err_d) begin
            state_d = ST_DONE;
          end else if (bus.req_store && (bus.req_funct3 == F3_W)) begin
            state_d  = ST_WR;
            mem_wd_d = bus.req_wdata;
            mem_we_d = 1'b1;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (cnt_q == LAT_C) begin
          if (store_q) begin
            state_d  = ST_MERGE;
            mem_wd_d = merge_data_s;
            mem_we_d = 1'b1;
          end else begin
            state_d = ST_DONE;
            rdata_d = load_data_s;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_WR:    state_d = ST_DONE;
      ST_MERGE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.stall  = ((state_q == ST_IDLE) & bus.req_valid) | (state_q == ST_RD) |
                      (state_q == ST_WR) | (state_q == ST_MERGE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;
  assign bus.mem_a  = mem_a_q;
  assign bus.mem_wd = mem_wd_q;
  assign bus.mem_we = mem_we_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl with a small datam model (MEM_RD_LAT=1) and a
// table of accesses whose expected results go through a scoreboard queue.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cyc;
    int          exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] dmem [0:63];
  vec_t sb_q[$];
  vec_t tbl [24];

  lsu_if bus();

  lsu_ctrl #(.MEM_RD_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.mem_rd <= dmem[bus.mem_a[7:2]];
    if (bus.mem_we) dmem[bus.mem_a[7:2]] <= bus.mem_wd;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input logic er,
                              input int cyc, input int we, input logic [31:0] ewd);
    vec_t v;
    v.store = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = rd;
    v.exp_err = er; v.exp_cyc = cyc; v.exp_we = we; v.exp_wd = ewd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   cyc;
    int   wec;
    logic got;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = v.store;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    sb_q.push_back(v);
    #1 chk("stall_on_req", 32'(bus.stall), 32'd1);
    cyc = 0;
    wec = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.mem_we) begin
        wec++;
        chk("mem_wd", bus.mem_wd, v.exp_wd);
      end
      if (bus.done) got = 1'b1;
    end
    e = sb_q.pop_front();
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: addr %h no done after %0d cycles", e.addr, cyc);
      bus.req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end else begin
      chk("rdata", bus.rdata, e.exp_rdata);
      chk("err", 32'(bus.err), 32'(e.exp_err));
      chk("done_cycle", 32'(cyc), 32'(e.exp_cyc));
      chk("we_cycles", 32'(wec), 32'(e.exp_we));
      chk("stall_in_done", 32'(bus.stall), 32'd0);
      if (!e.exp_err) chk("mem_a", bus.mem_a, {e.addr[31:2], 2'b00});
      bus.req_valid = 1'b0;
    end
  endtask

  initial begin
    int wec;
    for (int i = 0; i < 64; i++) dmem[i] = 32'h0;
    dmem[4] = 32'h8899AABB;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    tbl[0]  = mk(1'b0, F3_B,  32'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 3, 0, 32'h0);
    tbl[1]  = mk(1'b0, F3_HU, 32'h12, 32'h0,        32'h00008899, 1'b0, 3, 0, 32'h0);
    tbl[2]  = mk(1'b0, F3_H,  32'h12, 32'h0,        32'hFFFF8899, 1'b0, 3, 0, 32'h0);
    tbl[3]  = mk(1'b1, F3_B,  32'h13, 32'h12,       32'hFFFF8899, 1'b0, 4, 1, 32'h1299AABB);
    tbl[4]  = mk(1'b0, F3_W,  32'h10, 32'h0,        32'h1299AABB, 1'b0, 3, 0, 32'h0);
    tbl[5]  = mk(1'b1, F3_W,  32'h14, 32'hDEADBEEF, 32'h1299AABB, 1'b0, 2, 1, 32'hDEADBEEF);
    tbl[6]  = mk(1'b0, F3_W,  32'h14, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0, 32'h0);
    tbl[7]  = mk(1'b0, F3_BU, 32'h17, 32'h0,        32'h000000DE, 1'b0, 3, 0, 32'h0);
    tbl[8]  = mk(1'b0, F3_W,  32'h12, 32'h0,        32'h000000DE, 1'b1, 1, 0, 32'h0);
    tbl[9]  = mk(1'b1, F3_H,  32'h15, 32'hFFFF,     32'h000000DE, 1'b1, 1, 0, 32'h0);
    tbl[10] = mk(1'b0, 3'd3,  32'h14, 32'h0,        32'h000000DE, 1'b1, 1, 0, 32'h0);
    tbl[11] = mk(1'b0, 3'd6,  32'h14, 32'h0,        32'h000000DE, 1'b1, 1, 0, 32'h0);
    tbl[12] = mk(1'b1, 3'd3,  32'h14, 32'h0,        32'h000000DE, 1'b1, 1, 0, 32'h0);
    tbl[13] = mk(1'b1, F3_BU, 32'h14, 32'h0,        32'h000000DE, 1'b1, 1, 0, 32'h0);
    tbl[14] = mk(1'b0, F3_HU, 32'h16, 32'h0,        32'h0000DEAD, 1'b0, 3, 0, 32'h0);
    tbl[15] = mk(1'b0, F3_H,  32'h16, 32'h0,        32'hFFFFDEAD, 1'b0, 3, 0, 32'h0);
    tbl[16] = mk(1'b1, F3_H,  32'h16, 32'hCAFE1234, 32'hFFFFDEAD, 1'b0, 4, 1, 32'h1234BEEF);
    tbl[17] = mk(1'b0, F3_W,  32'h14, 32'h0,        32'h1234BEEF, 1'b0, 3, 0, 32'h0);
    tbl[18] = mk(1'b0, F3_B,  32'h15, 32'h0,        32'hFFFFFFBE, 1'b0, 3, 0, 32'h0);
    tbl[19] = mk(1'b0, F3_BU, 32'h14, 32'h0,        32'h000000EF, 1'b0, 3, 0, 32'h0);
    tbl[20] = mk(1'b0, F3_H,  32'h14, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 0, 32'h0);
    tbl[21] = mk(1'b1, F3_B,  32'h10, 32'hAB,       32'hFFFFBEEF, 1'b0, 4, 1, 32'h1299AAAB);
    tbl[22] = mk(1'b0, F3_H,  32'h11, 32'h0,        32'hFFFFBEEF, 1'b1, 1, 0, 32'h0);
    tbl[23] = mk(1'b0, F3_W,  32'h10, 32'h0,        32'h1299AAAB, 1'b0, 3, 0, 32'h0);

    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wd", bus.mem_wd, 32'h0);
    reset = 1'b0;

    // Reset in the middle of the MERGE write of an SH must abandon the store.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = F3_H;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h00005555;
    wec = 0;
    while (!bus.mem_we && wec < 10) begin
      @(negedge clk);
      wec++;
    end
    chk("merge_we_seen", 32'(bus.mem_we), 32'd1);
    chk("merge_cycle", 32'(wec), 32'd3);
    reset = 1'b1;
    bus.req_valid = 1'b0;
    #1;
    chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("midrst_stall", 32'(bus.stall), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_word", dmem[4], 32'h8899AABB);
    run_vec(mk(1'b0, F3_W, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 3, 0, 32'h0));

    for (int i = 0; i < 24; i++) run_vec(tbl[i]);

    chk("final_word10", dmem[4], 32'h1299AAAB);
    chk("final_word14", dmem[5], 32'h1234BEEF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
